// File: rtl/sub64_pipe.sv
// sub64_pipe: pipelined 64-bit unsigned subtractor (x - y) with a 65-bit result.
// One ADD_WIDTH-bit slice is subtracted per stage and the borrow is registered
// between stages. A valid bit travels with the data and a global enable stalls
// every register at once. diff[64] is the final borrow (1 iff x < y).
module sub64_pipe #(
  parameter int ADD_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic        out_valid,
  output logic [64:0] diff
);

  localparam int STAGES = 64 / ADD_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operands arrive already shifted so the slice to use is always the low one.
      logic [63:0]        x_in;
      logic [63:0]        y_in;
      logic [63:0]        res_in;
      logic               borrow_in;
      logic               valid_in;
      logic [ADD_WIDTH:0] slice_sub;
      logic [63:0]        res_next;
      logic [63:0]        res_reg;
      logic               borrow_reg;
      logic               valid_reg;

      if (gi == 0) begin : g_src
        assign x_in      = x;
        assign y_in      = y;
        assign res_in    = 64'h0;
        assign borrow_in = 1'b0;
        assign valid_in  = in_valid;
      end else begin : g_src
        assign x_in      = g_stage[gi-1].g_fwd.x_reg;
        assign y_in      = g_stage[gi-1].g_fwd.y_reg;
        assign res_in    = g_stage[gi-1].res_reg;
        assign borrow_in = g_stage[gi-1].borrow_reg;
        assign valid_in  = g_stage[gi-1].valid_reg;
      end

      // Slice subtract at ADD_WIDTH+1 bits; the MSB is the borrow-out.
      assign slice_sub = {1'b0, x_in[ADD_WIDTH-1:0]}
                       - {1'b0, y_in[ADD_WIDTH-1:0]}
                       - {{ADD_WIDTH{1'b0}}, borrow_in};

      // Earlier slice results pass through; this stage fills in its own slice.
      assign res_next = res_in | (64'(slice_sub[ADD_WIDTH-1:0]) << (gi * ADD_WIDTH));

      // Result, borrow and valid registers: cleared by reset, held while en is low.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg    <= 64'h0;
          borrow_reg <= 1'b0;
          valid_reg  <= 1'b0;
        end else if (en) begin
          res_reg    <= res_next;
          borrow_reg <= slice_sub[ADD_WIDTH];
          valid_reg  <= valid_in;
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        logic [63:0] x_reg;
        logic [63:0] y_reg;

        // Unused upper operand slices, shifted down so the next stage reads its low slice.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            x_reg <= 64'h0;
            y_reg <= 64'h0;
          end else if (en) begin
            x_reg <= x_in >> ADD_WIDTH;
            y_reg <= y_in >> ADD_WIDTH;
          end
        end
      end else if (ADD_WIDTH < 64) begin : g_tail
        // The last stage only consumes the low slice; the rest is always zero.
        logic unused_hi;
        assign unused_hi = ^{x_in[63:ADD_WIDTH], y_in[63:ADD_WIDTH]};
      end
    end
  endgenerate

  // Outputs come straight from the final stage's registers.
  assign diff      = {g_stage[STAGES-1].borrow_reg, g_stage[STAGES-1].res_reg};
  assign out_valid = g_stage[STAGES-1].valid_reg;

endmodule

// File: tb/tb_sub64_pipe.sv
// tb_sub64_pipe: directed self-checking bench for sub64_pipe (ADD_WIDTH = 16).
module tb_sub64_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [63:0] x;
  logic [63:0] y;
  logic        out_valid;
  logic [64:0] diff;

  int total = 0;
  int bad   = 0;

  sub64_pipe #(.ADD_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .diff      (diff)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    x        = 64'h0;
    y        = 64'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || diff !== 65'h0) begin
        bad++;
        $display("FAIL reset_hold: out_valid=%b diff=%h required out_valid=0 diff=0", out_valid, diff);
      end
      x        = {$urandom, $urandom};
      y        = {$urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_release_idle: out_valid=%b required 0", out_valid);
      end
    end
    $display("reset: held and released");
  endtask

  task automatic test_single_op();
    @(negedge clk);
    x        = 64'd5;
    y        = 64'd3;
    in_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (c == 4)) begin
        bad++;
        $display("FAIL single_valid c=%0d: out_valid=%b required %b", c, out_valid, (c == 4));
      end
      if (c == 4) begin
        total++;
        if (diff !== 65'h0_0000_0000_0000_0002) begin
          bad++;
          $display("FAIL single_diff: diff=%h required %h", diff, 65'h0_0000_0000_0000_0002);
        end
      end
      if (c == 1) begin
        in_valid = 1'b0;
        x        = {$urandom, $urandom};
        y        = {$urandom, $urandom};
      end
    end
    $display("single_op: 5 - 3");
  endtask

  task automatic test_borrow_ripple();
    logic [63:0] xv [6];
    logic [63:0] yv [6];
    logic [64:0] ev [6];
    xv[0] = 64'h0000_0000_0001_0000; yv[0] = 64'h1;                   ev[0] = 65'h0_0000_0000_0000_FFFF;
    xv[1] = 64'h0;                   yv[1] = 64'h1;                   ev[1] = 65'h1_FFFF_FFFF_FFFF_FFFF;
    xv[2] = 64'h8000_0000_0000_0000; yv[2] = 64'h1;                   ev[2] = 65'h0_7FFF_FFFF_FFFF_FFFF;
    xv[3] = 64'h1234_5678_9ABC_DEF0; yv[3] = 64'h1234_5678_9ABC_DEF0; ev[3] = 65'h0;
    xv[4] = 64'h0;                   yv[4] = 64'hFFFF_FFFF_FFFF_FFFF; ev[4] = 65'h1_0000_0000_0000_0001;
    xv[5] = 64'hFFFF_0000_0000_0000; yv[5] = 64'h1;                   ev[5] = 65'h0_FFFE_FFFF_FFFF_FFFF;
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      x        = xv[v];
      y        = yv[v];
      in_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        total++;
        if (out_valid !== (c == 4)) begin
          bad++;
          $display("FAIL ripple%0d_valid c=%0d: out_valid=%b required %b", v, c, out_valid, (c == 4));
        end
        if (c == 4) begin
          total++;
          if (diff !== ev[v]) begin
            bad++;
            $display("FAIL ripple%0d_diff: diff=%h required %h", v, diff, ev[v]);
          end
        end
        if (c == 1) in_valid = 1'b0;
      end
      $display("borrow_ripple %0d: x=%h y=%h", v, xv[v], yv[v]);
    end
  endtask

  task automatic test_stream();
    int n_valid = 0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (c >= 4 && c <= 23)) begin
        bad++;
        $display("FAIL stream_valid c=%0d: out_valid=%b required %b", c, out_valid, (c >= 4 && c <= 23));
      end
      if (out_valid === 1'b1) begin
        n_valid++;
        total++;
        if (diff !== 65'd100) begin
          bad++;
          $display("FAIL stream_diff c=%0d: diff=%h required %h", c, diff, 65'd100);
        end
      end
      if (c < 20) begin
        x        = 64'(c + 100);
        y        = 64'(c);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    total++;
    if (n_valid != 20) begin
      bad++;
      $display("FAIL stream_count: results=%0d required 20", n_valid);
    end
    $display("stream: 20 back-to-back ops, %0d results", n_valid);
  endtask

  task automatic test_stall();
    int          next_i  = 0;
    int          exp_idx = 0;
    logic        en_prev = 1'b1;
    logic        last_v  = 1'b0;
    logic [64:0] last_d  = 65'h0;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      if (!en_prev) begin
        total++;
        if (out_valid !== last_v || diff !== last_d) begin
          bad++;
          $display("FAIL stall_frozen t=%0d: out_valid=%b diff=%h required %b %h", t, out_valid, diff, last_v, last_d);
        end
      end else if (out_valid === 1'b1) begin
        total++;
        if (diff !== 65'(100 + 2 * exp_idx)) begin
          bad++;
          $display("FAIL stall_order t=%0d: diff=%h required %h", t, diff, 65'(100 + 2 * exp_idx));
        end
        exp_idx++;
      end
      last_v = out_valid;
      last_d = diff;
      en = !(t >= 8 && t <= 10);
      en_prev = en;
      if (!en) begin
        x        = 64'hDEAD_BEEF_0000_0000;
        y        = 64'h1;
        in_valid = 1'b1;
      end else if (next_i < 20) begin
        x        = 64'(next_i * 3 + 100);
        y        = 64'(next_i);
        in_valid = 1'b1;
        next_i++;
      end else begin
        in_valid = 1'b0;
      end
    end
    en = 1'b1;
    total++;
    if (exp_idx != 20) begin
      bad++;
      $display("FAIL stall_count: results=%0d required 20", exp_idx);
    end
    $display("stall: 3-cycle stall mid-stream, %0d results", exp_idx);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x        = 64'(300 + 2 * i);
      y        = 64'(i);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || diff !== 65'd300) begin
      bad++;
      $display("FAIL midstream_first: out_valid=%b diff=%h required 1 %h", out_valid, diff, 65'd300);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || diff !== 65'h0) begin
      bad++;
      $display("FAIL midstream_async_clear: out_valid=%b diff=%h required 0 0", out_valid, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midstream_stale c=%0d: out_valid=%b required 0", c, out_valid);
      end
    end
    x        = 64'd9;
    y        = 64'd4;
    in_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (c == 4)) begin
        bad++;
        $display("FAIL midstream_new_valid c=%0d: out_valid=%b required %b", c, out_valid, (c == 4));
      end
      if (c == 4) begin
        total++;
        if (diff !== 65'd5) begin
          bad++;
          $display("FAIL midstream_new_diff: diff=%h required %h", diff, 65'd5);
        end
      end
      if (c == 1) in_valid = 1'b0;
    end
    $display("reset_midstream: flushed and restarted");
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_borrow_ripple();
    test_stream();
    test_stall();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
